rock_control: RTL and testbench



---
 rtl/rock_control.sv | 201 ++++++++++++++++++++
 tb/tb_rock_control.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rock_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : rock_control                                                     |
// | Purpose  : Closed-loop cradle rocking controller. Walks a fixed table of     |
// |            (speed, amplitude) modes, keeps a mode while it lowers stress     |
// |            often enough per evaluation window, and ramps the speed setpoint  |
// |            one step per RAMP_CYCLES clocks.                                  |
// | Options  : ROCK_MODE_MEMORY_EN - restart from the last successful mode.      |
// | Revision : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module rock_control #(
  parameter int EVAL_CYCLES = 1024,
  parameter int MIN_EVENTS  = 4,
  parameter int RAMP_CYCLES = 16
) (
  input  logic       clk,
  input  logic       r,
  input  logic       aan,
  input  logic       stressLaag,
  output logic [2:0] snelheid,
  output logic [1:0] amplitude,
  output logic [1:0] modus,
  output logic       actief,
  output logic       kalm
);

  localparam int WIN_W = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;
  localparam int RMP_W = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;

  localparam logic [WIN_W-1:0] C_WIN_LAST = WIN_W'(EVAL_CYCLES - 1);
  localparam logic [RMP_W-1:0] C_RMP_LAST = RMP_W'(RAMP_CYCLES - 1);
  localparam logic [7:0]       C_EVT_MIN  = 8'(MIN_EVENTS);

  typedef enum logic [1:0] {
    ST_UIT  = 2'd0,
    ST_RAMP = 2'd1,
    ST_EVAL = 2'd2,
    ST_STOP = 2'd3
  } state_t;

  // Mode table: speed target per mode.
  function automatic logic [2:0] speed_of(input logic [1:0] m);
    case (m)
      2'd0:    speed_of = 3'd2;
      2'd1:    speed_of = 3'd3;
      2'd2:    speed_of = 3'd5;
      default: speed_of = 3'd6;
    endcase
  endfunction

  // Mode table: amplitude per mode.
  function automatic logic [1:0] amp_of(input logic [1:0] m);
    case (m)
      2'd0:    amp_of = 2'd1;
      2'd1:    amp_of = 2'd2;
      2'd2:    amp_of = 2'd2;
      default: amp_of = 2'd3;
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       snelheid_q, snelheid_d;
  logic [1:0]       amplitude_q, amplitude_d;
  logic [1:0]       modus_q, modus_d;
  logic             actief_q, actief_d;
  logic             kalm_q, kalm_d;
  logic [RMP_W-1:0] ramp_cnt_q, ramp_cnt_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [7:0]       evt_cnt_q, evt_cnt_d;

  logic [2:0]       w_target;
  logic [7:0]       w_evt_next;
  logic [1:0]       w_next_mode;
  logic [1:0]       w_start_mode;

`ifdef ROCK_MODE_MEMORY_EN
  logic [1:0]       mem_q, mem_d;
  assign w_start_mode = mem_q;
`else
  assign w_start_mode = 2'd0;
`endif

  // STOP always ramps toward zero; otherwise follow the current mode.
  assign w_target    = (state_q == ST_STOP) ? 3'd0 : speed_of(modus_q);
  // Saturating event count including this cycle's event.
  assign w_evt_next  = (evt_cnt_q == 8'hFF) ? 8'hFF : evt_cnt_q + {7'd0, stressLaag};
  assign w_next_mode = modus_q + 2'd1;

  // Next-state and setpoint logic.
  always_comb begin
    state_d     = state_q;
    snelheid_d  = snelheid_q;
    amplitude_d = amplitude_q;
    modus_d     = modus_q;
    kalm_d      = 1'b0;
    ramp_cnt_d  = ramp_cnt_q;
    win_cnt_d   = win_cnt_q;
    evt_cnt_d   = evt_cnt_q;
`ifdef ROCK_MODE_MEMORY_EN
    mem_d       = mem_q;
`endif

    case (state_q)
      ST_UIT: begin
        if (aan) begin
          modus_d     = w_start_mode;
          amplitude_d = amp_of(w_start_mode);
          ramp_cnt_d  = '0;
          state_d     = ST_RAMP;
        end
      end

      ST_RAMP, ST_STOP: begin
        if ((state_q == ST_RAMP) && !aan) begin
          ramp_cnt_d = '0;
          state_d    = ST_STOP;
        end else if (snelheid_q == w_target) begin
          if (state_q == ST_STOP) begin
            amplitude_d = 2'd0;
            state_d     = ST_UIT;
          end else begin
            win_cnt_d = '0;
            evt_cnt_d = 8'd0;
            state_d   = ST_EVAL;
          end
        end else if (ramp_cnt_q == C_RMP_LAST) begin
          ramp_cnt_d = '0;
          snelheid_d = (snelheid_q < w_target) ? snelheid_q + 3'd1 : snelheid_q - 3'd1;
        end else begin
          ramp_cnt_d = ramp_cnt_q + RMP_W'(1);
        end
      end

      default: begin // ST_EVAL
        if (!aan) begin
          // Disable wins over a coinciding window end.
          ramp_cnt_d = '0;
          state_d    = ST_STOP;
        end else if (win_cnt_q == C_WIN_LAST) begin
          win_cnt_d = '0;
          evt_cnt_d = 8'd0;
          if (w_evt_next >= C_EVT_MIN) begin
            kalm_d = 1'b1;
`ifdef ROCK_MODE_MEMORY_EN
            mem_d  = modus_q;
`endif
          end else begin
            modus_d     = w_next_mode;
            amplitude_d = amp_of(w_next_mode);
            ramp_cnt_d  = '0;
            state_d     = ST_RAMP;
          end
        end else begin
          win_cnt_d = win_cnt_q + WIN_W'(1);
          evt_cnt_d = w_evt_next;
        end
      end
    endcase

    actief_d = (state_d != ST_UIT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (r) begin
      state_q     <= ST_UIT;
      snelheid_q  <= 3'd0;
      amplitude_q <= 2'd0;
      modus_q     <= 2'd0;
      actief_q    <= 1'b0;
      kalm_q      <= 1'b0;
      ramp_cnt_q  <= '0;
      win_cnt_q   <= '0;
      evt_cnt_q   <= 8'd0;
`ifdef ROCK_MODE_MEMORY_EN
      mem_q       <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      snelheid_q  <= snelheid_d;
      amplitude_q <= amplitude_d;
      modus_q     <= modus_d;
      actief_q    <= actief_d;
      kalm_q      <= kalm_d;
      ramp_cnt_q  <= ramp_cnt_d;
      win_cnt_q   <= win_cnt_d;
      evt_cnt_q   <= evt_cnt_d;
`ifdef ROCK_MODE_MEMORY_EN
      mem_q       <= mem_d;
`endif
    end
  end

  assign snelheid  = snelheid_q;
  assign amplitude = amplitude_q;
  assign modus     = modus_q;
  assign actief    = actief_q;
  assign kalm      = kalm_q;

endmodule
`default_nettype wire

// File: tb/tb_rock_control.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_rock_control                                                  |
// | Purpose  : Self-checking bench for rock_control: randomized stimulus        |
// |            against a behavioural model, directed restart/reset sequences   |
// |            and a saturation check on a long-window instance.                |
// | Options  : ROCK_MODE_MEMORY_EN changes the expected restart mode.           |
// | Revision : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_rock_control;

  localparam int EVAL = 32;
  localparam int MINE = 2;
  localparam int RAMP = 4;

  logic       clk = 1'b0;
  logic       r = 1'b1, aan = 1'b0, sl = 1'b0;
  logic [2:0] snelheid;
  logic [1:0] amplitude, modus;
  logic       actief, kalm;

  logic       r_s = 1'b1, aan_s = 1'b0, sl_s = 1'b0;
  logic [2:0] snelheid_s;
  logic [1:0] amplitude_s, modus_s;
  logic       actief_s, kalm_s;

  always #5 clk = ~clk;

  rock_control #(.EVAL_CYCLES(EVAL), .MIN_EVENTS(MINE), .RAMP_CYCLES(RAMP)) u_dut (
    .clk(clk), .r(r), .aan(aan), .stressLaag(sl),
    .snelheid(snelheid), .amplitude(amplitude), .modus(modus),
    .actief(actief), .kalm(kalm)
  );

  // Long-window instance: 300 events must saturate at 255 and still succeed.
  rock_control #(.EVAL_CYCLES(512), .MIN_EVENTS(255), .RAMP_CYCLES(RAMP)) u_dut_sat (
    .clk(clk), .r(r_s), .aan(aan_s), .stressLaag(sl_s),
    .snelheid(snelheid_s), .amplitude(amplitude_s), .modus(modus_s),
    .actief(actief_s), .kalm(kalm_s)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int spd(input int m);
    int t[4] = '{2, 3, 5, 6};
    return t[m];
  endfunction

  function automatic int amp(input int m);
    int t[4] = '{1, 2, 2, 3};
    return t[m];
  endfunction

  int m_speed = 0, m_amp = 0, m_mode = 0, m_mem = 0;
  int m_tick = 0, m_age = 0, m_hits = 0;
  bit m_on = 0, m_halting = 0, m_settled = 0, m_kalm = 0;
  bit chk_en = 0;

  // Model advances on the same edge the design samples its inputs.
  always @(posedge clk) begin
    m_kalm = 0;
    if (r) begin
      m_speed = 0; m_amp = 0; m_mode = 0; m_mem = 0;
      m_tick = 0; m_age = 0; m_hits = 0;
      m_on = 0; m_halting = 0; m_settled = 0;
    end else if (!m_on) begin
      if (aan) begin
`ifdef ROCK_MODE_MEMORY_EN
        m_mode = m_mem;
`else
        m_mode = 0;
`endif
        m_amp = amp(m_mode);
        m_on = 1; m_halting = 0; m_settled = 0; m_tick = 0;
      end
    end else if (m_halting) begin
      if (m_speed == 0) begin
        m_amp = 0; m_on = 0; m_halting = 0;
      end else if (++m_tick == RAMP) begin
        m_tick = 0; m_speed--;
      end
    end else if (!aan) begin
      m_halting = 1; m_tick = 0;
    end else if (!m_settled) begin
      if (m_speed == spd(m_mode)) begin
        m_settled = 1; m_age = 0; m_hits = 0;
      end else if (++m_tick == RAMP) begin
        m_tick = 0;
        m_speed += (m_speed < spd(m_mode)) ? 1 : -1;
      end
    end else begin
      m_hits = (m_hits + sl > 255) ? 255 : m_hits + sl;
      m_age++;
      if (m_age == EVAL) begin
        if (m_hits >= MINE) begin
          m_kalm = 1; m_mem = m_mode;
        end else begin
          m_mode = (m_mode + 1) % 4;
          m_amp = amp(m_mode);
          m_settled = 0; m_tick = 0;
        end
        m_age = 0; m_hits = 0;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("snelheid", snelheid, m_speed);
      check_eq("amplitude", amplitude, m_amp);
      check_eq("modus", modus, m_mode);
      check_eq("actief", actief, m_on);
      check_eq("kalm", kalm, m_kalm);
    end
  end

  // ---------------- stimulus ----------------
  int exp_mode, exp_speed;
  bit found;

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check_eq("rst_snelheid", snelheid, 0);
    check_eq("rst_amplitude", amplitude, 0);
    check_eq("rst_modus", modus, 0);
    check_eq("rst_actief", actief, 0);
    check_eq("rst_kalm", kalm, 0);
    chk_en = 1;
    r = 0;
    repeat (3) @(negedge clk);

    // Walk to mode 2 by failing windows, succeed there, stop, restart.
    aan = 1;
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (m_mode == 2 && m_settled && m_age == 0) found = 1;
    end
    check_eq("reach_mode2", found, 1);
    sl = 1;
    repeat (3) @(negedge clk);
    sl = 0;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (kalm) found = 1;
    end
    check_eq("mode2_kalm", found, 1);
    aan = 0;
    @(negedge clk);
    aan = 1;                 // pulse during STOP must be ignored
    @(negedge clk);
    aan = 0;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (!m_on && !actief) found = 1;
    end
    check_eq("stopped", found, 1);
    check_eq("stop_amp", amplitude, 0);
    aan = 1;
    @(negedge clk);
`ifdef ROCK_MODE_MEMORY_EN
    exp_mode = 2; exp_speed = 5;
`else
    exp_mode = 0; exp_speed = 2;
`endif
    check_eq("restart_modus", modus, exp_mode);
    check_eq("restart_actief", actief, 1);
    check_eq("restart_amp", amplitude, (exp_mode == 2) ? 2 : 1);
    repeat (5) @(negedge clk);
    check_eq("ramp_first_step", snelheid, 1);

    // Reset in the middle of a ramp.
    r = 1;
    @(negedge clk);
    r = 0;
    check_eq("midramp_snelheid", snelheid, 0);
    check_eq("midramp_amp", amplitude, 0);
    check_eq("midramp_modus", modus, 0);
    check_eq("midramp_actief", actief, 0);
    check_eq("midramp_kalm", kalm, 0);

    // Restart and confirm the ramp target for the start mode.
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (m_settled) found = 1;
    end
    check_eq("settle_after_reset", found, 1);
    check_eq("settled_speed", snelheid, 2);

    // Randomized segments.
    for (int s = 0; s < 70; s++) begin
      automatic int len  = $urandom_range(10, 150);
      automatic int dsel = $urandom_range(0, 3);
      automatic int dens = (dsel == 0) ? 0 : (dsel == 1) ? 40 : (dsel == 2) ? 12 : 3;
      if ($urandom_range(0, 99) < 5) begin
        @(negedge clk);
        r = 1;
        @(negedge clk);
        r = 0;
      end
      aan = ($urandom_range(0, 99) < 85);
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        sl = (dens != 0) && ($urandom_range(0, dens - 1) == 0);
        if ($urandom_range(0, 99) < 2) aan = ~aan;
      end
    end
    @(negedge clk);
    sl = 0;

    // Saturation on the long-window instance.
    repeat (2) @(negedge clk);
    check_eq("sat_rst_actief", actief_s, 0);
    r_s = 0;
    aan_s = 1;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (snelheid_s == 3'd2) found = 1;
    end
    check_eq("sat_ramp", found, 1);
    sl_s = 1;
    repeat (300) @(negedge clk);
    sl_s = 0;
    found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (kalm_s) found = 1;
    end
    check_eq("sat_kalm", found, 1);
    check_eq("sat_modus", modus_s, 0);
    @(negedge clk);
    check_eq("sat_kalm_one_cycle", kalm_s, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
